two_func_engine: RTL

TWO_FUNC_ENGINE -- requirements
Module: two_func_engine

---
 rtl/calc_pkg.sv | 15 +
 rtl/shift_add_datapath.sv | 67 ++++++
 rtl/two_func_engine.sv | 94 +++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the two-function (add / multiply) engine.
//   state_t : FSM state encoding used by two_func_engine.
//   FN_ADD / FN_MUL : values driven on FSEL to pick the operation.
package calc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_t;

  localparam logic FN_ADD = 1'b0;
  localparam logic FN_MUL = 1'b1;

endpackage

// File: rtl/shift_add_datapath.sv
// Operand capture and shift-add arithmetic for two_func_engine.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture a, b, fsel and restart the counter (IDLE with START)
//   step       : advance one multiplier bit (asserted while the FSM is in RUN)
//   a, b, fsel : operands and function select from the top level
//   result     : final result valid in the last RUN cycle (combinational)
//   last       : this RUN cycle is the final one
module shift_add_datapath
  import calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           fsel,
  output logic [2*N-1:0] result,
  output logic           last
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] a_sh_q;
  logic [N-1:0]   b_sh_q;
  logic [CW-1:0]  cnt_q;
  logic           fsel_q;

  // Multiplicand shifts left, multiplier shifts right: bit 0 of b_sh_q is
  // always the multiplier bit for the current cycle.
  always_comb begin
    acc_d = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    if (fsel_q == FN_MUL) begin
      result = acc_d;
      last   = (cnt_q == CW'(1));
    end else begin
      result = a_sh_q + {{N{1'b0}}, b_sh_q};
      last   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      fsel_q <= FN_ADD;
    end else if (load) begin
      acc_q  <= '0;
      a_sh_q <= {{N{1'b0}}, a};
      b_sh_q <= b;
      cnt_q  <= CW'(N);
      fsel_q <= fsel;
    end else if (step && fsel_q == FN_MUL) begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/two_func_engine.sv
// Two-function engine: R = A + B (1 RUN cycle) or R = A * B (N RUN cycles,
// shift-add). START in IDLE captures operands; DONE pulses for one cycle when
// R is loaded; BUSY is high in RUN and DONE.
// Ports:
//   CLK, CLR     : clock, asynchronous active-low reset
//   A, B, FSEL   : operands and function select (0 add, 1 multiply)
//   START        : request, honoured only in IDLE
//   BUSY, DONE   : status
//   R            : 2N-bit result, held until the next DONE
//   OVF          : R[2N-1:N] != 0; only when CALC_OVF_EN is defined
module two_func_engine
  import calc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           FSEL,
  input  logic           START,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*N-1:0] R
`ifdef CALC_OVF_EN
  ,
  output logic           OVF
`endif
);

  state_t         state_q, state_d;
  logic           load, step, last;
  logic [2*N-1:0] result;
  logic [2*N-1:0] r_q;

  shift_add_datapath #(
    .N(N)
  ) u_datapath (
    .clk   (CLK),
    .rst_n (CLR),
    .load  (load),
    .step  (step),
    .a     (A),
    .b     (B),
    .fsel  (FSEL),
    .result(result),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // R only loads on the RUN->DONE edge, so partial products never appear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                          r_q <= '0;
    else if (state_q == StRun && last) r_q <= result;
  end

  assign R    = r_q;
  assign BUSY = (state_q == StRun) || (state_q == StDone);
  assign DONE = (state_q == StDone);

`ifdef CALC_OVF_EN
  logic ovf_q;
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                          ovf_q <= 1'b0;
    else if (state_q == StRun && last) ovf_q <= |result[2*N-1:N];
  end
  assign OVF = ovf_q;
`endif

endmodule
